// File: rtl/note_square_synth_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// note_square_synth_if : audio controller FIFO sample/handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface note_square_synth_if;
  logic        audio_in_available;
  logic        audio_out_allowed;
  logic [31:0] left_in;
  logic [31:0] right_in;
  logic [31:0] left_out;
  logic [31:0] right_out;
  logic        read_audio_in;
  logic        write_audio_out;

  modport master (
    input  audio_in_available,
    input  audio_out_allowed,
    input  left_in,
    input  right_in,
    output left_out,
    output right_out,
    output read_audio_in,
    output write_audio_out
  );

  modport slave (
    output audio_in_available,
    output audio_out_allowed,
    output left_in,
    output right_in,
    input  left_out,
    input  right_out,
    input  read_audio_in,
    input  write_audio_out
  );
endinterface
`default_nettype wire

// File: rtl/note_square_synth.sv
`default_nettype none
// ---------------------------------------------------------------------------
// note_square_synth : note-ROM melody player mixing a square wave into audio
// Rev 1.0
// ---------------------------------------------------------------------------
module note_square_synth #(
  parameter int          ADDR_W     = 10,
  parameter int          DATA_W     = 20,
  parameter logic [31:0] AMPLITUDE  = 32'd1000000000,
  parameter logic [26:0] GAP_CYCLES = 27'd500000
) (
  input  wire logic                CLOCK_50,
  input  wire logic                reset,
  input  wire logic                enable,
  input  wire logic [ADDR_W-1:0]   last_addr,
  input  wire logic [26:0]         tempo_limit,
  output logic      [ADDR_W-1:0]   rom_address,
  input  wire logic [DATA_W-1:0]   rom_q,
  note_square_synth_if.master      audio,
  output logic                     playing
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LATCH = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] TONE_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
  logic [DATA_W-1:0]   half_period_q, half_period_d;
  logic [DATA_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic [26:0]         tempo_cnt_q, tempo_cnt_d;
  logic                phase_q, phase_d;

  logic                tempo_hit;
  logic                in_gap;
  logic [31:0]         sound;

  assign tempo_hit = (tempo_cnt_q >= tempo_limit);
  // 28-bit sum so a large GAP_CYCLES cannot wrap and unmute the note
  assign in_gap    = ({1'b0, tempo_cnt_q} + {1'b0, GAP_CYCLES}) > {1'b0, tempo_limit};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rom_address_q <= '0;
      half_period_q <= '0;
      tone_cnt_q    <= '0;
      tempo_cnt_q   <= '0;
      phase_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_address_q <= rom_address_d;
      half_period_q <= half_period_d;
      tone_cnt_q    <= tone_cnt_d;
      tempo_cnt_q   <= tempo_cnt_d;
      phase_q       <= phase_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rom_address_d = rom_address_q;
    half_period_d = half_period_q;
    tone_cnt_d    = tone_cnt_q;
    tempo_cnt_d   = tempo_cnt_q;
    phase_d       = phase_q;

    if (!enable) begin
      // pause: address held, note restarts from LATCH on resume
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          half_period_d = rom_q;
          tone_cnt_d    = '0;
          tempo_cnt_d   = '0;
          phase_d       = 1'b0;
          state_d       = S_PLAY;
        end
        S_PLAY: begin
          if (tempo_hit) begin
            rom_address_d = (rom_address_q >= last_addr) ? '0 : rom_address_q + ADDR_ONE;
            state_d       = S_FETCH;
          end else begin
            tempo_cnt_d = tempo_cnt_q + 27'd1;
          end
          if (tone_cnt_q == half_period_q) begin
            tone_cnt_d = '0;
            phase_d    = ~phase_q;
          end else begin
            tone_cnt_d = tone_cnt_q + TONE_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sound = 32'd0;
    if ((state_q == S_PLAY) && !in_gap && (half_period_q != '0)) begin
      sound = phase_q ? AMPLITUDE : (32'd0 - AMPLITUDE);
    end
  end

  assign audio.left_out        = audio.left_in  + sound;
  assign audio.right_out       = audio.right_in + sound;
  assign audio.read_audio_in   = audio.audio_in_available & audio.audio_out_allowed;
  assign audio.write_audio_out = audio.audio_in_available & audio.audio_out_allowed;
  assign rom_address           = rom_address_q;
  assign playing               = (state_q == S_PLAY);

endmodule
`default_nettype wire

// File: tb/tb_note_square_synth.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_note_square_synth : directed self-checking bench for note_square_synth
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_note_square_synth;

  localparam logic [31:0] AMP   = 32'd1000000000;
  localparam int          GAP   = 4;
  localparam logic [31:0] R_IN  = 32'd100;

  logic        CLOCK_50;
  logic        reset;
  logic        enable;
  logic [9:0]  last_addr;
  logic [26:0] tempo_limit;
  logic [9:0]  rom_address;
  logic [19:0] rom_q;
  logic        playing;
  logic [19:0] rom [0:3];

  int errors;
  int checks;

  note_square_synth_if aud ();

  note_square_synth #(
    .ADDR_W     (10),
    .DATA_W     (20),
    .AMPLITUDE  (AMP),
    .GAP_CYCLES (27'd4)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .enable      (enable),
    .last_addr   (last_addr),
    .tempo_limit (tempo_limit),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .audio       (aud.master),
    .playing     (playing)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // synchronous ROM: data one cycle after the address
  always @(posedge CLOCK_50) rom_q <= rom[rom_address[1:0]];

  function automatic logic [31:0] model(input int i, input int half, input int limit);
    if (half == 0 || i + GAP > limit) return 32'd0;
    return (((i / (half + 1)) % 2) == 1) ? AMP : (32'd0 - AMP);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic fetch(input int addr);
    chk($sformatf("fetch a%0d playing", addr), {31'd0, playing}, 32'd0);
    chk($sformatf("fetch a%0d addr", addr), {22'd0, rom_address}, addr);
    chk($sformatf("fetch a%0d left", addr), aud.left_out, 32'd0);
    tick();
    chk($sformatf("latch a%0d playing", addr), {31'd0, playing}, 32'd0);
    chk($sformatf("latch a%0d right", addr), aud.right_out, R_IN);
    tick();
  endtask

  task automatic play_range(input int half, input int limit, input int addr,
                            input int from, input int to);
    for (int i = from; i < to; i++) begin
      chk($sformatf("play a%0d i%0d playing", addr, i), {31'd0, playing}, 32'd1);
      chk($sformatf("play a%0d i%0d addr", addr, i), {22'd0, rom_address}, addr);
      chk($sformatf("play a%0d i%0d left", addr, i), aud.left_out, model(i, half, limit));
      chk($sformatf("play a%0d i%0d right", addr, i), aud.right_out, R_IN + model(i, half, limit));
      tick();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    enable = 1'b0;
    last_addr = 10'd0;
    tempo_limit = 27'd40;
    aud.audio_in_available = 1'b0;
    aud.audio_out_allowed  = 1'b0;
    aud.left_in  = 32'd5;
    aud.right_in = 32'd7;
    rom[0] = 20'd3; rom[1] = 20'd0; rom[2] = 20'd0; rom[3] = 20'd0;
    tick(); tick(); tick();

    // reset state and pass-through
    chk("reset left",    aud.left_out,  32'd5);
    chk("reset right",   aud.right_out, 32'd7);
    chk("reset addr",    {22'd0, rom_address}, 32'd0);
    chk("reset playing", {31'd0, playing}, 32'd0);
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        aud.audio_in_available = a[0];
        aud.audio_out_allowed  = b[0];
        #1;
        chk($sformatf("rd strobe %0d%0d", a, b), {31'd0, aud.read_audio_in},   {31'd0, a[0] & b[0]});
        chk($sformatf("wr strobe %0d%0d", a, b), {31'd0, aud.write_audio_out}, {31'd0, a[0] & b[0]});
      end
    end

    // single note, repeated via wrap on last_addr=0
    aud.left_in  = 32'd0;
    aud.right_in = R_IN;
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    fetch(0);
    play_range(3, 40, 0, 0, 41);
    fetch(0);
    play_range(3, 40, 0, 0, 10);

    // reset mid-note
    reset = 1'b1;
    tick();
    chk("midreset playing", {31'd0, playing}, 32'd0);
    chk("midreset addr",    {22'd0, rom_address}, 32'd0);
    chk("midreset left",    aud.left_out, 32'd0);

    // wrap across three notes, note 1 is a rest
    rom[0] = 20'd2; rom[1] = 20'd0; rom[2] = 20'd5;
    last_addr   = 10'd2;
    tempo_limit = 27'd12;
    reset = 1'b0;
    tick();
    fetch(0);
    play_range(2, 12, 0, 0, 13);
    fetch(1);
    play_range(0, 12, 1, 0, 13);
    fetch(2);
    play_range(5, 12, 2, 0, 13);
    fetch(0);
    rom[1] = 20'd3;
    play_range(2, 12, 0, 0, 13);
    fetch(1);
    play_range(3, 12, 1, 0, 6);

    // pause and resume
    enable = 1'b0;
    tick();
    chk("pause playing", {31'd0, playing}, 32'd0);
    chk("pause addr",    {22'd0, rom_address}, 32'd1);
    chk("pause left",    aud.left_out, 32'd0);
    tick();
    chk("pause hold addr", {22'd0, rom_address}, 32'd1);
    enable = 1'b1;
    tick();
    fetch(1);
    play_range(3, 12, 1, 0, 4);

    // mixing wraps modulo 2^32 with sound = +A
    aud.left_in = 32'h7FFFFFFF;
    #1;
    chk("mix overflow", aud.left_out, 32'hBB9AC9FF);
    aud.left_in = 32'd0;
    #1;
    play_range(3, 12, 1, 4, 13);

    // live tempo decrease ends the note at once
    tempo_limit = 27'd40;
    fetch(2);
    play_range(5, 40, 2, 0, 30);
    tempo_limit = 27'd10;
    #1;
    chk("tempo drop playing", {31'd0, playing}, 32'd1);
    chk("tempo drop gap",     aud.left_out, 32'd0);
    tick();
    fetch(0);
    play_range(2, 10, 0, 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
